// File: rtl/ncsr_param_if.sv
// Handshake/bus bundle for the negacyclic shift register.
// Master drives control and load data; slave returns the coefficient state.
interface ncsr_param_if #(
   parameter int N = 4,
   parameter int W = 4
);
   logic             load;
   logic [N*W-1:0]   ddata;
   logic             start;
   logic [7:0]       steps;
   logic             mode_neg;
   logic             hold;
   logic [N*W-1:0]   dpoly;
   logic [W-1:0]     dcoef;
   logic             busy;
   logic             done;

   modport master (
      output load, ddata, start, steps, mode_neg, hold,
      input  dpoly, dcoef, busy, done
   );

   modport slave (
      input  load, ddata, start, steps, mode_neg, hold,
      output dpoly, dcoef, busy, done
   );
endinterface

// File: rtl/ncsr_param.sv
// Polynomial coefficient shift register: multiply-by-x modulo x^N-1 or x^N+1,
// one shift per non-held cycle; done pulses the cycle after the final shift.
module ncsr_param #(
   parameter int N = 4,
   parameter int W = 4,
   parameter int Q = 16
) (
   input  logic        clk,
   input  logic        reset,
   ncsr_param_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   localparam logic [W:0] QV = (W+1)'(Q);

   state_t           r_state;
   logic [N*W-1:0]   r_poly;
   logic [7:0]       r_cnt;
   logic             r_mode;
   logic             r_done;

   state_t           w_state_nxt;
   logic [N*W-1:0]   w_poly_nxt;
   logic [7:0]       w_cnt_nxt;
   logic             w_mode_nxt;
   logic             w_done_nxt;

   logic [W-1:0]     w_top;
   logic [W:0]       w_neg_wide;
   logic [W-1:0]     w_neg;
   logic [W-1:0]     w_new0;
   logic [N*W-1:0]   w_shift;

   // Q may equal 2^W, so the subtraction is carried one bit wider.
   assign w_top      = r_poly[(N-1)*W +: W];
   assign w_neg_wide = QV - {1'b0, w_top};
   assign w_neg      = (w_top == '0) ? '0 : w_neg_wide[W-1:0];
   assign w_new0     = r_mode ? w_neg : w_top;
   assign w_shift    = {r_poly[(N-1)*W-1:0], w_new0};

   always_comb begin
      w_state_nxt = r_state;
      w_poly_nxt  = r_poly;
      w_cnt_nxt   = r_cnt;
      w_mode_nxt  = r_mode;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.load) begin
               w_poly_nxt = bus.ddata;
            end else if (bus.start) begin
               if (bus.steps == 8'd0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = bus.steps;
                  w_mode_nxt  = bus.mode_neg;
               end
            end
         end
         ST_RUN: begin
            if (!bus.hold) begin
               w_poly_nxt = w_shift;
               w_cnt_nxt  = r_cnt - 8'd1;
               if (r_cnt == 8'd1) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_poly  <= '0;
         r_cnt   <= 8'd0;
         r_mode  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_poly  <= w_poly_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mode  <= w_mode_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.dpoly = r_poly;
   assign bus.dcoef = w_top;
   assign bus.busy  = (r_state == ST_RUN);
   assign bus.done  = r_done;

endmodule

// File: doc/ncsr_param.md
NCSR_PARAM -- requirements
Module: ncsr_param

Interface
REQ-001 Parameter N, default 4, number of polynomial coefficients held (N >= 2).
REQ-002 Parameter W, default 4, coefficient width in bits.
REQ-003 Parameter Q, default 16, coefficient modulus for negation (2 <= Q <= 2^W).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 load  in  1  capture ddata into the coefficient register (IDLE only).
REQ-007 ddata  in  N*W  packed coefficients; coefficient i at bits [i*W +: W].
REQ-008 start  in  1  begin a shift run (IDLE only).
REQ-009 steps  in  8  number of shifts in the run, sampled with start.
REQ-010 mode_neg  in  1  1 = negacyclic (x^N+1), 0 = plain cyclic; sampled with start.
REQ-011 hold  in  1  stall; while high in RUN, no shift occurs and the counter is frozen.
REQ-012 dpoly  out  N*W  current coefficient register, same packing as ddata.
REQ-013 dcoef  out  W  serial tap: coefficient N-1 of dpoly.
REQ-014 busy  out  1  high while in RUN.
REQ-015 done  out  1  one-cycle pulse at the end of a run.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 In IDLE, load=1 at an edge SHALL copy ddata into the coefficient register, visible on dpoly in the next cycle.
REQ-018 In IDLE, start=1 with load=0 and steps>0 SHALL latch steps and mode_neg, enter RUN, and assert busy from the next cycle.
REQ-019 In IDLE, start=1 with steps=0 SHALL stay in IDLE, change nothing, and pulse done in the next cycle.
REQ-020 If load and start are both high in IDLE, load SHALL take effect and start SHALL be ignored.
REQ-021 In RUN, each edge with hold=0 SHALL perform one shift: new[i] = old[i-1] for i = 1..N-1, and the remaining counter SHALL decrement.
REQ-022 On a shift, new[0] SHALL equal old[N-1] when mode_neg=0, or neg(old[N-1]) when mode_neg=1.
REQ-023 neg(c) SHALL be 0 for c=0 and Q-c otherwise, computed in W bits.
REQ-024 Input coefficients SHALL be below Q; stimulus with values at or above Q is illegal.
REQ-025 The edge performing the final shift SHALL return the FSM to IDLE, so that in the next cycle busy=0, done=1 and dpoly shows the final value.
REQ-026 A run of S shifts with no hold SHALL occupy S cycles of busy after the start edge.
REQ-027 load and start in RUN SHALL be ignored.
REQ-028 hold in IDLE SHALL have no effect.
REQ-029 done SHALL never be high for two consecutive cycles unless a new zero-step start was issued.

Reset
REQ-030 While reset=1, the block SHALL immediately force dpoly=0, dcoef=0, busy=0, done=0, counter=0 and state=IDLE, regardless of the clock.
REQ-031 Reset mid-run SHALL abort the run without a done pulse.
REQ-032 The first edge after reset deasserts SHALL obey IDLE rules.

Verification (N=4, W=4, Q=16; load c3..c0 = 0, 1, 6, 10)
REQ-033 Cyclic, steps=1: the run SHALL produce dpoly c3..c0 = 1, 6, 10, 0; dcoef=1; done pulses in the cycle after the shift.
REQ-034 Negacyclic, steps=2: the run SHALL produce c3..c0 = 6, 10, 0, 15; dcoef=6.
REQ-035 Negacyclic, steps=4: the run SHALL produce c3..c0 = 0, 15, 10, 6; steps=8 SHALL restore 0, 1, 6, 10; cyclic steps=4 SHALL restore the original value.
REQ-036 Cyclic, steps=4 with hold high for 3 cycles mid-run: busy SHALL last 7 cycles, done SHALL come 3 cycles late, and the final dpoly SHALL be unchanged versus the no-hold run.
REQ-037 Reset asserted during the 2nd shift of a steps=4 run: all outputs SHALL go to 0 at once with no done pulse; a following load/start SHALL work normally.
REQ-038 steps=0 SHALL give done the next cycle with busy=0 and dpoly unchanged; load and start in the same cycle SHALL load ddata with no run started.
